// File: rtl/dac_pkg.sv
// Shared constants, state type and saturating arithmetic for the DAC dither sequencer.
package dac_pkg;

  localparam int unsigned DAC_WIDTH = 14;
  localparam logic [DAC_WIDTH-1:0] DAC_MIDSCALE = 14'h2000;
  localparam logic [DAC_WIDTH-1:0] DAC_MAX = 14'h3FFF;

  typedef enum logic [1:0] {
    StIdle,
    StPlus,
    StMinus
  } seq_state_e;

  typedef struct packed {
    logic [DAC_WIDTH-1:0] code;
    logic                 clamped;
  } sat_result_t;

  // base +/- amp in two extra bits of signed headroom, clamped to [0, DAC_MAX].
  function automatic sat_result_t sat_add(logic [DAC_WIDTH-1:0] base,
                                          logic [DAC_WIDTH-2:0] amp,
                                          logic                 neg);
    logic signed [DAC_WIDTH+1:0] sum;
    sat_result_t res;
    if (neg) begin
      sum = $signed({2'b00, base}) - $signed({3'b000, amp});
    end else begin
      sum = $signed({2'b00, base}) + $signed({3'b000, amp});
    end
    if (sum < 0) begin
      res.code    = '0;
      res.clamped = 1'b1;
    end else if (sum > $signed({2'b00, DAC_MAX})) begin
      res.code    = DAC_MAX;
      res.clamped = 1'b1;
    end else begin
      res.code    = sum[DAC_WIDTH-1:0];
      res.clamped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dac_dither_sequencer_if.sv
// Control and DAC-code signals between the SPGD controller and the dither sequencer.
interface dac_dither_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 14,
  parameter int unsigned HOLD_WIDTH = 16
);

  logic                  enable;
  logic                  start;
  logic [DATA_WIDTH-1:0] base_in;
  logic [DATA_WIDTH-2:0] dither_amp;
  logic                  dither_sign;
  logic [HOLD_WIDTH-1:0] hold_cycles;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  phase;
  logic                  phase_done;
  logic                  sat;
  logic                  sign_used;

  modport master (
    output enable, start, base_in, dither_amp, dither_sign, hold_cycles,
    input  data_out, busy, phase, phase_done, sat, sign_used
  );

  modport slave (
    input  enable, start, base_in, dither_amp, dither_sign, hold_cycles,
    output data_out, busy, phase, phase_done, sat, sign_used
  );

endinterface

// File: rtl/dither_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying pseudo-random dither signs.
module dither_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  output logic next_lsb
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        feedback;

  always_comb begin
    feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d   = advance ? {lfsr_q[14:0], feedback} : lfsr_q;
  end

  // LSB the register will hold after this advance; consumed in the same cycle.
  assign next_lsb = feedback;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/dac_dither_sequencer.sv
// SPGD dither sequencer: base+delta, base-delta, base, with per-phase strobes.
// Optional internal sign generator enabled by defining DITHER_LFSR_EN.
module dac_dither_sequencer
  import dac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DAC_WIDTH,
  parameter int unsigned HOLD_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic                   clk,
  input logic                   rst,
  dac_dither_sequencer_if.slave bus
);

  localparam logic [HOLD_WIDTH-1:0] HoldOne = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-2:0] amp_q, amp_d;
  logic                  sign_q, sign_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic [HOLD_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sat_q, sat_d;
  logic                  busy_q, busy_d;
  logic                  phase_q, phase_d;
  logic                  phase_done_q, phase_done_d;
  logic [HOLD_WIDTH-1:0] hold_eff;
  logic                  sign_in;
  sat_result_t           res;

  assign hold_eff = (bus.hold_cycles == '0) ? HoldOne : bus.hold_cycles;

`ifdef DITHER_LFSR_EN
  logic start_accept;
  logic lfsr_bit;
  logic unused_dither_sign;

  assign start_accept       = (state_q == StIdle) && bus.enable && bus.start;
  assign unused_dither_sign = bus.dither_sign;

  dither_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .advance  (start_accept),
    .next_lsb (lfsr_bit)
  );

  assign sign_in = lfsr_bit;
`else
  logic unused_seed;

  assign unused_seed = ^LFSR_SEED;
  assign sign_in     = bus.dither_sign;
`endif

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    amp_d   = amp_q;
    sign_d  = sign_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sat_d   = sat_q;
    busy_d  = busy_q;
    phase_d = phase_q;
    res     = sat_add(base_q, amp_q, ~sign_q);

    unique case (state_q)
      StIdle: begin
        // Idle output follows base_in one cycle late.
        base_d  = bus.base_in;
        data_d  = bus.base_in;
        sat_d   = 1'b0;
        busy_d  = 1'b0;
        phase_d = 1'b0;
        if (bus.enable && bus.start) begin
          res     = sat_add(bus.base_in, bus.dither_amp, sign_in);
          amp_d   = bus.dither_amp;
          sign_d  = sign_in;
          hold_d  = hold_eff;
          cnt_d   = hold_eff - HoldOne;
          state_d = StPlus;
          busy_d  = 1'b1;
          data_d  = res.code;
          sat_d   = res.clamped;
        end
      end
      StPlus: begin
        if (cnt_q == '0) begin
          state_d = StMinus;
          phase_d = 1'b1;
          cnt_d   = hold_q - HoldOne;
          data_d  = res.code;
          sat_d   = res.clamped;
        end else begin
          cnt_d = cnt_q - HoldOne;
        end
      end
      StMinus: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          phase_d = 1'b0;
          data_d  = base_q;
          sat_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - HoldOne;
        end
      end
      default: state_d = StIdle;
    endcase

    // Dropping enable discards a partial cycle and restores the latched base.
    if (!bus.enable && (state_q != StIdle)) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      phase_d = 1'b0;
      data_d  = base_q;
      sat_d   = 1'b0;
    end

    phase_done_d = (state_d != StIdle) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      base_q       <= DAC_MIDSCALE;
      amp_q        <= '0;
      sign_q       <= 1'b0;
      hold_q       <= HoldOne;
      cnt_q        <= '0;
      data_q       <= DAC_MIDSCALE;
      sat_q        <= 1'b0;
      busy_q       <= 1'b0;
      phase_q      <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      amp_q        <= amp_d;
      sign_q       <= sign_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      sat_q        <= sat_d;
      busy_q       <= busy_d;
      phase_q      <= phase_d;
      phase_done_q <= phase_done_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.busy       = busy_q;
  assign bus.phase      = phase_q;
  assign bus.phase_done = phase_done_q;
  assign bus.sat        = sat_q;
  assign bus.sign_used  = sign_q;

endmodule

// File: tb/tb_dac_dither_sequencer.sv
// Scoreboard bench for dac_dither_sequencer: expected per-cycle outputs queued at stimulus time.
module tb_dac_dither_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dac_dither_sequencer_if bus ();

  dac_dither_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [13:0] data;
    logic        busy;
    logic        phase;
    logic        pd;
    logic        sat;
    logic        sign;
    logic        chk_sign;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] lfsr_model = 16'hACE1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_rec(logic [13:0] data, logic busy, logic phase, logic pd,
                                   logic sat, logic sign, logic chk_sign);
    exp_t e;
    e.data     = data;
    e.busy     = busy;
    e.phase    = phase;
    e.pd       = pd;
    e.sat      = sat;
    e.sign     = sign;
    e.chk_sign = chk_sign;
    exp_q.push_back(e);
  endfunction

  task automatic check_cycle(input string tag, input int idx);
    exp_t e;
    if (exp_q.size() == 0) begin
      $display("FAIL %s[%0d]: scoreboard empty, got no expectation", tag, idx);
      $fatal(1);
    end
    e = exp_q.pop_front();
    check_eq($sformatf("%s[%0d].data", tag, idx), 32'(bus.data_out), 32'(e.data));
    check_eq($sformatf("%s[%0d].busy", tag, idx), 32'(bus.busy), 32'(e.busy));
    check_eq($sformatf("%s[%0d].phase_done", tag, idx), 32'(bus.phase_done), 32'(e.pd));
    check_eq($sformatf("%s[%0d].sat", tag, idx), 32'(bus.sat), 32'(e.sat));
    if (e.busy) begin
      check_eq($sformatf("%s[%0d].phase", tag, idx), 32'(bus.phase), 32'(e.phase));
    end
    if (e.chk_sign) begin
      check_eq($sformatf("%s[%0d].sign_used", tag, idx), 32'(bus.sign_used), 32'(e.sign));
    end
  endtask

  // Returns {clamped, code} for base +/- amp saturated to 14-bit offset binary.
  function automatic logic [14:0] ref_code(logic [13:0] base, logic [12:0] amp, logic neg);
    int v;
    v = neg ? (int'(base) - int'(amp)) : (int'(base) + int'(amp));
    if (v < 0) return {1'b1, 14'h0000};
    if (v > 16383) return {1'b1, 14'h3FFF};
    return {1'b0, v[13:0]};
  endfunction

  function automatic logic lfsr_step();
    logic fb;
    fb = lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10];
    lfsr_model = {lfsr_model[14:0], fb};
    return lfsr_model[0];
  endfunction

  // One perturbation cycle; optional re-start/input change at restart_at and enable drop at
  // abort_at (record index). Two idle cycles follow: latched base, then mid_base tracked.
  task automatic run_cycle(input string tag, input logic [13:0] base, input logic [12:0] amp,
                           input logic sign, input int hold, input int restart_at,
                           input int abort_at, input logic [13:0] mid_base);
    int          h;
    int          last;
    logic        s;
    logic [14:0] plus_r;
    logic [14:0] minus_r;
    h = (hold == 0) ? 1 : hold;
    s = sign;
`ifdef DITHER_LFSR_EN
    s = lfsr_step();
`endif
    plus_r  = ref_code(base, amp, s);
    minus_r = ref_code(base, amp, ~s);
    last    = (abort_at >= 0) ? abort_at : 2 * h - 1;
    for (int k = 0; k <= last; k++) begin
      if (k < h) push_rec(plus_r[13:0], 1'b1, 1'b0, k == h - 1, plus_r[14], s, 1'b1);
      else push_rec(minus_r[13:0], 1'b1, 1'b1, k == 2 * h - 1, minus_r[14], s, 1'b1);
    end
    push_rec(base, 1'b0, 1'b0, 1'b0, 1'b0, s, 1'b0);
    push_rec(mid_base, 1'b0, 1'b0, 1'b0, 1'b0, s, 1'b0);

    bus.base_in     = base;
    bus.dither_amp  = amp;
    bus.dither_sign = sign;
    bus.hold_cycles = 16'(hold);
    bus.enable      = 1'b1;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k <= last + 2; k++) begin
      check_cycle(tag, k);
      bus.start  = (k == restart_at);
      bus.enable = !((abort_at >= 0) && (k == last));
      if (k == restart_at) begin
        bus.base_in     = mid_base;
        bus.dither_amp  = 13'h1FFF;
        bus.hold_cycles = 16'd9;
        bus.dither_sign = ~sign;
      end
      tick();
    end
    bus.start  = 1'b0;
    bus.enable = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [14:0] r;
    rst             = 1'b1;
    bus.enable      = 1'b1;
    bus.start       = 1'b0;
    bus.base_in     = 14'h2000;
    bus.dither_amp  = 13'h0000;
    bus.dither_sign = 1'b0;
    bus.hold_cycles = 16'd1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset release: midscale, idle, for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      push_rec(14'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_cycle("reset", k);
      tick();
    end

    run_cycle("basic", 14'h2000, 13'h0100, 1'b0, 4, -1, -1, 14'h2000);
    run_cycle("sat_hi", 14'h3F80, 13'h0100, 1'b0, 2, -1, -1, 14'h3F80);
    run_cycle("sat_lo", 14'h0040, 13'h0100, 1'b1, 2, -1, -1, 14'h0040);
    run_cycle("hold0", 14'h1800, 13'h0333, 1'b0, 0, -1, -1, 14'h1800);
    run_cycle("restart", 14'h2000, 13'h0080, 1'b0, 3, 1, -1, 14'h1000);
    run_cycle("abort", 14'h2400, 13'h0200, 1'b1, 5, -1, 6, 14'h2400);

    // Reset during the plus phase.
    bus.base_in     = 14'h1234;
    bus.dither_amp  = 13'h0100;
    bus.dither_sign = 1'b1;
    bus.hold_cycles = 16'd4;
    bus.start       = 1'b1;
`ifdef DITHER_LFSR_EN
    r = ref_code(14'h1234, 13'h0100, lfsr_step());
    push_rec(r[13:0], 1'b1, 1'b0, 1'b0, r[14], lfsr_model[0], 1'b1);
`else
    r = ref_code(14'h1234, 13'h0100, 1'b1);
    push_rec(r[13:0], 1'b1, 1'b0, 1'b0, r[14], 1'b1, 1'b1);
`endif
    tick();
    bus.start = 1'b0;
    check_cycle("rst_mid", 0);
    rst = 1'b1;
    lfsr_model = 16'hACE1;
    tick();
    push_rec(14'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_cycle("rst_mid", 1);
    rst = 1'b0;
    tick();
    push_rec(14'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_cycle("rst_mid", 2);

`ifdef DITHER_LFSR_EN
    for (int i = 0; i < 8; i++) begin
      run_cycle($sformatf("lfsr%0d", i), 14'h2000, 13'h0040, i[0], 1, -1, -1, 14'h2000);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_dither_sequencer.md
Name: dac_dither_sequencer

Overview:
- Upstream source stage for the DAC output path. Generates the offset-binary 14-bit DAC code that the offset-to-two's-complement stage converts before it reaches the AD9745.
- On each start request it runs one SPGD perturbation cycle:
  - holds base+delta for a programmable number of cycles,
  - then holds base−delta,
  - then returns to base.
- Pulses strobes so the metric sampler can measure each phase.
- All outputs are registered and saturated to the valid offset-binary range.

Parameters:
- DATA_WIDTH, 14, DAC code width (offset binary).
- HOLD_WIDTH, 16, width of the per-phase hold counter.
- LFSR_SEED, 16'hACE1, non-zero reset seed of the optional internal sign generator.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  sequencer enable; low aborts any cycle in progress.
- start  in  1  single-cycle request to run one perturbation cycle.
- base_in  in  DATA_WIDTH  control value, offset binary.
- dither_amp  in  DATA_WIDTH-1  unsigned perturbation magnitude.
- dither_sign  in  1  perturbation sign (0 = +amp, 1 = −amp); ignored when DITHER_LFSR_EN is defined.
- hold_cycles  in  HOLD_WIDTH  cycles per phase; 0 is treated as 1.
- data_out  out  DATA_WIDTH  offset-binary DAC code to the converter stage.
- busy  out  1  high from the cycle after start acceptance until return to IDLE.
- phase  out  1  0 = plus phase, 1 = minus phase; valid while busy.
- phase_done  out  1  one-cycle pulse on the last cycle of each phase.
- sat  out  1  high while the current data_out was clamped.
- sign_used  out  1  sign latched for the current cycle.

Behaviour:
- Reset:
  - state=IDLE, data_out = 2^(DATA_WIDTH-1) (14'h2000, midscale), busy=0, phase=0, phase_done=0, sat=0, sign_used=0, counter=0.
  - Latched base = 14'h2000.
- States: IDLE, PLUS, MINUS.
- IDLE:
  - data_out = latched base; busy=0.
  - start=1 && enable=1 at edge t:
    - latch base_in, dither_amp, sign and max(hold_cycles,1);
    - at t+1: state=PLUS, busy=1, phase=0, data_out = sat(base + s·amp), counter loaded with hold−1.
  - start=0 or enable=0 → stay in IDLE.
  - base_in is re-latched every IDLE cycle, so data_out tracks base_in with 1-cycle latency.
- PLUS:
  - Counter decrements each cycle.
  - On the cycle the counter reads 0, phase_done=1.
  - Next edge: state=MINUS, phase=1, data_out = sat(base − s·amp), counter reloaded.
- MINUS:
  - Same counting rule.
  - At counter 0, phase_done=1; next edge: state=IDLE, busy=0, data_out = latched base.
- Phase timing: each phase outputs its code for exactly hold cycles. A full cycle is 2·hold cycles with busy=1.
- Arithmetic and saturation:
  - s·amp = +amp when sign=0, −amp when sign=1.
  - Sums are computed in DATA_WIDTH+2-bit signed arithmetic.
  - Results below 0 clamp to 0; results above 2^DATA_WIDTH−1 clamp to 2^DATA_WIDTH−1 (14'h3FFF).
  - sat=1 for the clamped phase only.
- start while busy: ignored, with no queueing.
- Input changes mid-cycle: base_in, dither_amp and hold_cycles changes during busy have no effect until the next start.
- enable low while busy: next edge → IDLE, busy=0, phase_done=0, data_out = latched base. The partial cycle is discarded.
- rst mid-cycle: returns all outputs to their reset values on the next edge.
- Back-to-back cycles: start asserted in the first IDLE cycle after MINUS is accepted, giving one IDLE cycle between perturbation cycles.

Optional Feature:
- DITHER_LFSR_EN defined:
  - Sign comes from an internal 16-bit Fibonacci LFSR (taps 16,14,13,11) seeded with LFSR_SEED on rst.
  - The LFSR advances once per accepted start; the sign is its LSB.
  - dither_sign is ignored.
- DITHER_LFSR_EN undefined: no LFSR logic; the sign is taken from dither_sign at start acceptance.

Decomposition:
- Shared package (dac_pkg):
  - DAC_WIDTH=14;
  - DAC_MIDSCALE=14'h2000;
  - DAC_MAX=14'h3FFF;
  - the state enum type (IDLE/PLUS/MINUS);
  - the saturating add function.
- One sub-module: dither_lfsr (seeded LFSR with advance strobe), instantiated only under DITHER_LFSR_EN.

Test Plan:
- Reset release → data_out=14'h2000, busy=0, sat=0 for 10 cycles with start=0.
- base=14'h2000, amp=13'h0100, sign=0, hold=4, start pulse:
  - data_out 14'h2100 for 4 cycles, then 14'h1F00 for 4 cycles, then 14'h2000;
  - busy=1 for exactly 8 cycles;
  - phase_done pulses on cycles 4 and 8.
- base=14'h3F80, amp=13'h0100, sign=0, hold=2:
  - plus phase data_out=14'h3FFF with sat=1;
  - minus phase 14'h3E80 with sat=0.
- Repeat with base=14'h0040, sign=1: plus phase 14'h0000 with sat=1; minus phase 14'h0140.
- hold=0 → each phase lasts 1 cycle.
- start re-pulsed during PLUS → no effect; total busy still 2·hold.
- enable dropped on the 2nd MINUS cycle (hold=5) → IDLE next cycle, data_out=base, no second phase_done.
- rst asserted during PLUS → all outputs at reset values next cycle.
- DITHER_LFSR_EN: 8 successive starts produce the sign sequence predicted by the reference model from seed 16'hACE1; toggling dither_sign has no effect.
